countdown_timer_mmss: RTL and testbench



---
 rtl/countdown_timer_mmss.sv | 159 +++++++++++++++
 tb/tb_countdown_timer_mmss.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/countdown_timer_mmss.sv
// rtl/countdown_timer_mmss.sv - loadable BCD MM:SS countdown timer with alarm hold-off
// Optional build macro: TIMER_AUTO_RELOAD_EN (periodic reload on expiry instead of alarm).
module countdown_timer_mmss #(
    parameter int unsigned ALARM_TICKS = 8
) (
    input  logic       Clk,
    input  logic       Clr,
    input  logic       Tick,
    input  logic       LD,
    input  logic [7:0] LD_MIN,
    input  logic [7:0] LD_SEC,
    input  logic       Start,
    input  logic       Stop,
    output logic [7:0] MIN,
    output logic [7:0] SEC,
    output logic       RUNNING,
    output logic       ALARM,
    output logic       DONE,
    output logic       LOAD_ERR
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

    state_t     state_q, state_nx;
    logic [7:0] min_q, sec_q, min_nx, sec_nx;
    logic [7:0] acnt_q, acnt_nx;
    logic       done_q, done_nx, lerr_q, lerr_nx;
    logic [7:0] dec_min, dec_sec;
    logic       b_s1, b_s10, b_m1;
    logic       ld_ok, is_zero, dec_zero;
`ifdef TIMER_AUTO_RELOAD_EN
    logic [7:0] rl_min_q, rl_sec_q, rl_min_nx, rl_sec_nx;
`endif

    assign ld_ok = (LD_MIN[7:4] <= 4'd9) && (LD_MIN[3:0] <= 4'd9) &&
                   (LD_SEC[7:4] <= 4'd5) && (LD_SEC[3:0] <= 4'd9);
    assign is_zero  = (min_q == 8'h00) && (sec_q == 8'h00);
    assign dec_zero = (dec_min == 8'h00) && (dec_sec == 8'h00);

    // Per-digit BCD borrow chain; only evaluated in RUN where the value is nonzero.
    always_comb begin
        b_s1  = (sec_q[3:0] == 4'd0);
        b_s10 = b_s1 && (sec_q[7:4] == 4'd0);
        b_m1  = b_s10 && (min_q[3:0] == 4'd0);
        dec_sec[3:0] = b_s1 ? 4'd9 : 4'(sec_q[3:0] - 4'd1);
        dec_sec[7:4] = !b_s1 ? sec_q[7:4] :
                       ((sec_q[7:4] == 4'd0) ? 4'd5 : 4'(sec_q[7:4] - 4'd1));
        dec_min[3:0] = !b_s10 ? min_q[3:0] :
                       ((min_q[3:0] == 4'd0) ? 4'd9 : 4'(min_q[3:0] - 4'd1));
        dec_min[7:4] = b_m1 ? 4'(min_q[7:4] - 4'd1) : min_q[7:4];
    end

    always_comb begin
        state_nx = state_q;
        min_nx   = min_q;
        sec_nx   = sec_q;
        acnt_nx  = acnt_q;
        done_nx  = 1'b0;
        lerr_nx  = 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
        rl_min_nx = rl_min_q;
        rl_sec_nx = rl_sec_q;
`endif
        case (state_q)
            IDLE, PAUSE: begin
                if (Stop) begin
                    state_nx = state_q;
                end else if (Start) begin
                    if (state_q == PAUSE || !is_zero)
                        state_nx = RUN;
                end else if (LD) begin
                    if (ld_ok) begin
                        min_nx   = LD_MIN;
                        sec_nx   = LD_SEC;
                        state_nx = IDLE;
`ifdef TIMER_AUTO_RELOAD_EN
                        rl_min_nx = LD_MIN;
                        rl_sec_nx = LD_SEC;
`endif
                    end else begin
                        lerr_nx = 1'b1;
                    end
                end
            end
            RUN: begin
                if (Stop) begin
                    state_nx = PAUSE;
                end else if (Tick) begin
                    min_nx = dec_min;
                    sec_nx = dec_sec;
                    if (dec_zero) begin
                        done_nx  = 1'b1;
                        state_nx = EXPIRED;
                        acnt_nx  = 8'd0;
`ifdef TIMER_AUTO_RELOAD_EN
                        if ((rl_min_q != 8'h00) || (rl_sec_q != 8'h00)) begin
                            min_nx   = rl_min_q;
                            sec_nx   = rl_sec_q;
                            state_nx = RUN;
                        end
`endif
                    end
                end
            end
            EXPIRED: begin
                if (Stop || Start) begin
                    state_nx = IDLE;
                    acnt_nx  = 8'd0;
                end else if (Tick) begin
                    if (acnt_q == 8'(ALARM_TICKS - 1)) begin
                        state_nx = IDLE;
                        acnt_nx  = 8'd0;
                    end else begin
                        acnt_nx = acnt_q + 8'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q <= IDLE;
            min_q   <= 8'h00;
            sec_q   <= 8'h00;
            acnt_q  <= 8'd0;
            done_q  <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            state_q <= state_nx;
            min_q   <= min_nx;
            sec_q   <= sec_nx;
            acnt_q  <= acnt_nx;
            done_q  <= done_nx;
            lerr_q  <= lerr_nx;
        end
    end

`ifdef TIMER_AUTO_RELOAD_EN
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            rl_min_q <= 8'h00;
            rl_sec_q <= 8'h00;
        end else begin
            rl_min_q <= rl_min_nx;
            rl_sec_q <= rl_sec_nx;
        end
    end
`endif

    assign MIN      = min_q;
    assign SEC      = sec_q;
    assign RUNNING  = (state_q == RUN);
    assign ALARM    = (state_q == EXPIRED);
    assign DONE     = done_q;
    assign LOAD_ERR = lerr_q;

endmodule

// File: tb/tb_countdown_timer_mmss.sv
// tb/tb_countdown_timer_mmss.sv - directed self-checking bench for countdown_timer_mmss
module tb_countdown_timer_mmss;

    logic       Clk = 1'b0;
    logic       Clr = 1'b0;
    logic       Tick = 1'b0, LD = 1'b0, Start = 1'b0, Stop = 1'b0;
    logic [7:0] LD_MIN = 8'h00, LD_SEC = 8'h00;
    logic [7:0] MIN, SEC;
    logic       RUNNING, ALARM, DONE, LOAD_ERR;

    int n_chk  = 0;
    int n_pass = 0;

    countdown_timer_mmss #(.ALARM_TICKS(8)) dut (
        .Clk(Clk), .Clr(Clr), .Tick(Tick), .LD(LD), .LD_MIN(LD_MIN), .LD_SEC(LD_SEC),
        .Start(Start), .Stop(Stop), .MIN(MIN), .SEC(SEC), .RUNNING(RUNNING),
        .ALARM(ALARM), .DONE(DONE), .LOAD_ERR(LOAD_ERR)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic load(input logic [7:0] m, input logic [7:0] s);
        LD = 1'b1; LD_MIN = m; LD_SEC = s;
        step();
        LD = 1'b0;
    endtask

    task automatic start();
        Start = 1'b1; step(); Start = 1'b0;
    endtask

    task automatic stop();
        Stop = 1'b1; step(); Stop = 1'b0;
    endtask

    task automatic tick();
        Tick = 1'b1; step(); Tick = 1'b0;
        step();
    endtask

    initial begin
        #12;
        check("rst_val",  {MIN, SEC}, 16'h0000);
        check("rst_flags", {12'h0, RUNNING, ALARM, DONE, LOAD_ERR}, 16'h0000);
        Clr = 1'b1;
        step();

        load(8'h01, 8'h00);
        check("ld_0100", {MIN, SEC}, 16'h0100);
        check("ld_0100_err", {15'h0, LOAD_ERR}, 16'h0000);
        start();
        check("run_after_start", {15'h0, RUNNING}, 16'h0001);
        Tick = 1'b1; step(); Tick = 1'b0;
        check("dec_0059", {MIN, SEC}, 16'h0059);
        check("run_held", {15'h0, RUNNING}, 16'h0001);
        step();
        check("no_tick_hold", {MIN, SEC}, 16'h0059);
        tick();
        check("dec_0058", {MIN, SEC}, 16'h0058);

        load(8'h05, 8'h00);
        check("ld_in_run_ign", {MIN, SEC}, 16'h0058);
        check("ld_in_run_noerr", {15'h0, LOAD_ERR}, 16'h0000);

        Stop = 1'b1; Tick = 1'b1; step(); Stop = 1'b0; Tick = 1'b0;
        check("stop_tick_val", {MIN, SEC}, 16'h0058);
        check("stop_paused", {15'h0, RUNNING}, 16'h0000);

        load(8'h1A, 8'h00);
        check("bad_min_err", {15'h0, LOAD_ERR}, 16'h0001);
        check("bad_min_val", {MIN, SEC}, 16'h0058);
        step();
        check("err_one_cycle", {15'h0, LOAD_ERR}, 16'h0000);
        load(8'h00, 8'h60);
        check("bad_sec_err", {15'h0, LOAD_ERR}, 16'h0001);
        check("bad_sec_val", {MIN, SEC}, 16'h0058);
        check("bad_ld_still_pause", {15'h0, RUNNING}, 16'h0000);

        Start = 1'b1; Tick = 1'b1; step(); Start = 1'b0; Tick = 1'b0;
        check("resume_tick_ign", {MIN, SEC}, 16'h0058);
        check("resumed", {15'h0, RUNNING}, 16'h0001);
        tick();
        check("dec_0057", {MIN, SEC}, 16'h0057);

        stop();
        load(8'h10, 8'h00);
        check("pause_ld_1000", {MIN, SEC}, 16'h1000);
        start();
        tick();
        check("dec_0959", {MIN, SEC}, 16'h0959);

        load(8'h00, 8'h00);
        stop();
        load(8'h00, 8'h30);
        start();
        #2;
        Clr = 1'b0;
        #1;
        check("clr_async_val", {MIN, SEC}, 16'h0000);
        check("clr_async_flags", {12'h0, RUNNING, ALARM, DONE, LOAD_ERR}, 16'h0000);
        step();
        Clr = 1'b1;
        start();
        check("start_zero_ign", {15'h0, RUNNING}, 16'h0000);

`ifdef TIMER_AUTO_RELOAD_EN
        load(8'h00, 8'h03);
        start();
        tick(); tick();
        Tick = 1'b1; step(); Tick = 1'b0;
        check("ar_done", {15'h0, DONE}, 16'h0001);
        check("ar_reload", {MIN, SEC}, 16'h0003);
        check("ar_run_noalarm", {14'h0, RUNNING, ALARM}, 16'h0002);
        step();
        check("ar_done_pulse", {15'h0, DONE}, 16'h0000);
`else
        load(8'h00, 8'h02);
        start();
        tick();
        check("dec_0001", {MIN, SEC}, 16'h0001);
        Tick = 1'b1; step(); Tick = 1'b0;
        check("exp_val", {MIN, SEC}, 16'h0000);
        check("exp_done_alarm", {13'h0, RUNNING, ALARM, DONE}, 16'h0003);
        step();
        check("done_pulse", {14'h0, ALARM, DONE}, 16'h0002);
        for (int i = 0; i < 7; i++) tick();
        check("alarm_after_7", {15'h0, ALARM}, 16'h0001);
        tick();
        check("alarm_after_8", {15'h0, ALARM}, 16'h0000);
        check("no_wrap", {MIN, SEC}, 16'h0000);

        load(8'h00, 8'h01);
        start();
        Tick = 1'b1; step(); Tick = 1'b0;
        check("exp2_alarm", {15'h0, ALARM}, 16'h0001);
        stop();
        check("ack_alarm", {15'h0, ALARM}, 16'h0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
